// File: rtl/hdl_tdm_demux_4ch.sv
// Receive-side TDM demultiplexer: regenerates the slot select from a SYNC marker,
// collects slots 0..2 in shadow registers and publishes all four channels together.
module hdl_tdm_demux_4ch #(
  parameter int unsigned WIDTH = 1
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic [WIDTH-1:0] Y,
  input  logic             SYNC,
  input  logic             EN,
  output logic [WIDTH-1:0] D0,
  output logic [WIDTH-1:0] D1,
  output logic [WIDTH-1:0] D2,
  output logic [WIDTH-1:0] D3,
  output logic             S1,
  output logic             S0,
  output logic             FRAME_VALID,
  output logic             SYNC_ERR,
  output logic             LOCKED
);

  typedef enum logic {
    ST_HUNT   = 1'b0,
    ST_LOCKED = 1'b1
  } state_e;

  state_e           state_q, state_d;
  logic [1:0]       slot_q, slot_d;
  logic [WIDTH-1:0] sh0_q, sh0_d;
  logic [WIDTH-1:0] sh1_q, sh1_d;
  logic [WIDTH-1:0] sh2_q, sh2_d;
  logic [WIDTH-1:0] d0_q, d0_d;
  logic [WIDTH-1:0] d1_q, d1_d;
  logic [WIDTH-1:0] d2_q, d2_d;
  logic [WIDTH-1:0] d3_q, d3_d;
  logic             fv_q, fv_d;
  logic             err_q, err_d;

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q <= ST_HUNT;
      slot_q  <= '0;
      sh0_q   <= '0;
      sh1_q   <= '0;
      sh2_q   <= '0;
      d0_q    <= '0;
      d1_q    <= '0;
      d2_q    <= '0;
      d3_q    <= '0;
      fv_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      slot_q  <= slot_d;
      sh0_q   <= sh0_d;
      sh1_q   <= sh1_d;
      sh2_q   <= sh2_d;
      d0_q    <= d0_d;
      d1_q    <= d1_d;
      d2_q    <= d2_d;
      d3_q    <= d3_d;
      fv_q    <= fv_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    slot_d  = slot_q;
    sh0_d   = sh0_q;
    sh1_d   = sh1_q;
    sh2_d   = sh2_q;
    d0_d    = d0_q;
    d1_d    = d1_q;
    d2_d    = d2_q;
    d3_d    = d3_q;
    fv_d    = 1'b0;
    err_d   = 1'b0;
    if (EN) begin
      unique case (state_q)
        ST_HUNT: begin
          if (SYNC) begin
            sh0_d   = Y;
            slot_d  = 2'd1;
            state_d = ST_LOCKED;
          end
        end
        ST_LOCKED: begin
          if (slot_q == 2'd0) begin
            if (SYNC) begin
              sh0_d  = Y;
              slot_d = 2'd1;
            end else begin
              err_d   = 1'b1;
              state_d = ST_HUNT;
            end
          end else if (SYNC) begin
            // Early marker: abandon the partial frame and restart it at slot 0.
            err_d  = 1'b1;
            sh0_d  = Y;
            slot_d = 2'd1;
          end else begin
            unique case (slot_q)
              2'd1: sh1_d = Y;
              2'd2: sh2_d = Y;
              default: begin
                d0_d = sh0_q;
                d1_d = sh1_q;
                d2_d = sh2_q;
                d3_d = Y;
                fv_d = 1'b1;
              end
            endcase
            slot_d = slot_q + 2'd1;
          end
        end
        default: state_d = ST_HUNT;
      endcase
    end
  end

  always_comb begin
    D0          = d0_q;
    D1          = d1_q;
    D2          = d2_q;
    D3          = d3_q;
    S1          = slot_q[1];
    S0          = slot_q[0];
    FRAME_VALID = fv_q;
    SYNC_ERR    = err_q;
    LOCKED      = (state_q == ST_LOCKED);
  end

endmodule

// File: tb/tb_hdl_tdm_demux_4ch.sv
// Directed bench for hdl_tdm_demux_4ch: walks through locking, framing, EN gaps,
// early/missing markers and mid-frame reset with hand-computed expectations.
module tb_hdl_tdm_demux_4ch;

  logic CLK = 1'b0;
  logic RST_N = 1'b0;
  logic [0:0] Y = '0;
  logic SYNC = 1'b0;
  logic EN = 1'b0;
  logic [0:0] D0, D1, D2, D3;
  logic S1, S0, FRAME_VALID, SYNC_ERR, LOCKED;

  int unsigned vectors = 0;
  int unsigned miscompares = 0;

  hdl_tdm_demux_4ch #(.WIDTH(1)) dut (
    .CLK(CLK), .RST_N(RST_N), .Y(Y), .SYNC(SYNC), .EN(EN),
    .D0(D0), .D1(D1), .D2(D2), .D3(D3), .S1(S1), .S0(S0),
    .FRAME_VALID(FRAME_VALID), .SYNC_ERR(SYNC_ERR), .LOCKED(LOCKED)
  );

  always #5 CLK = ~CLK;

  task automatic step(input logic y, input logic s, input logic e);
    Y = y; SYNC = s; EN = e;
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Checks data word {D0,D1,D2,D3}, slot {S1,S0} and flags {FV,ERR,LOCKED}.
  task automatic all(input string tag, input logic [3:0] d, input logic [1:0] s,
                     input logic fv, input logic err, input logic lk);
    chk({tag, ".D"},   {D0, D1, D2, D3}, d);
    chk({tag, ".S"},   {2'b00, S1, S0}, {2'b00, s});
    chk({tag, ".FLG"}, {1'b0, FRAME_VALID, SYNC_ERR, LOCKED}, {1'b0, fv, err, lk});
  endtask

  initial begin
    // 1: reset, first frame 1,0,1,1
    RST_N = 1'b0;
    step(1'b1, 1'b1, 1'b1);
    all("rst", 4'b0000, 2'b00, 0, 0, 0);
    RST_N = 1'b1;
    step(1'b0, 1'b0, 1'b1);
    all("hunt_nosync", 4'b0000, 2'b00, 0, 0, 0);
    step(1'b1, 1'b1, 1'b1);
    all("t1_s0", 4'b0000, 2'b01, 0, 0, 1);
    step(1'b0, 1'b0, 1'b1);
    all("t1_s1", 4'b0000, 2'b10, 0, 0, 1);
    step(1'b1, 1'b0, 1'b1);
    all("t1_s2", 4'b0000, 2'b11, 0, 0, 1);
    step(1'b1, 1'b0, 1'b1);
    all("t1_s3", 4'b1011, 2'b00, 1, 0, 1);

    // 2: back-to-back frames 0,1,0,1 then 1,1,0,0
    step(1'b0, 1'b1, 1'b1);
    all("t2a_s0", 4'b1011, 2'b01, 0, 0, 1);
    step(1'b1, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b1);
    all("t2a_s2", 4'b1011, 2'b11, 0, 0, 1);
    step(1'b1, 1'b0, 1'b1);
    all("t2a_s3", 4'b0101, 2'b00, 1, 0, 1);
    step(1'b1, 1'b1, 1'b1);
    all("t2b_s0", 4'b0101, 2'b01, 0, 0, 1);
    step(1'b1, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b1);
    all("t2b_s2", 4'b0101, 2'b11, 0, 0, 1);
    step(1'b0, 1'b0, 1'b1);
    all("t2b_s3", 4'b1100, 2'b00, 1, 0, 1);

    // 3: EN gaps through frame 1,1,1,0; junk on Y/SYNC while EN=0
    step(1'b1, 1'b1, 1'b1);
    all("t3_s0", 4'b1100, 2'b01, 0, 0, 1);
    step(1'b0, 1'b1, 1'b0);
    all("t3_gap0", 4'b1100, 2'b01, 0, 0, 1);
    step(1'b1, 1'b0, 1'b1);
    all("t3_s1", 4'b1100, 2'b10, 0, 0, 1);
    step(1'b0, 1'b1, 1'b0);
    all("t3_gap1", 4'b1100, 2'b10, 0, 0, 1);
    step(1'b1, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b0);
    all("t3_gap2", 4'b1100, 2'b11, 0, 0, 1);
    step(1'b0, 1'b0, 1'b1);
    all("t3_s3", 4'b1110, 2'b00, 1, 0, 1);
    step(1'b1, 1'b1, 1'b0);
    all("t3_gap3", 4'b1110, 2'b00, 0, 0, 1);

    // 4: early marker at slot 2, then 0,1,1 completes resynced frame
    step(1'b1, 1'b1, 1'b1);
    step(1'b0, 1'b0, 1'b1);
    all("t4_pre", 4'b1110, 2'b10, 0, 0, 1);
    step(1'b1, 1'b1, 1'b1);
    all("t4_early", 4'b1110, 2'b01, 0, 1, 1);
    step(1'b0, 1'b0, 1'b1);
    all("t4_s1", 4'b1110, 2'b10, 0, 0, 1);
    step(1'b1, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b1);
    all("t4_s3", 4'b1011, 2'b00, 1, 0, 1);

    // 5: missing marker at slot 0 drops lock; no-SYNC samples ignored; relock
    step(1'b1, 1'b0, 1'b1);
    all("t5_miss", 4'b1011, 2'b00, 0, 1, 0);
    step(1'b1, 1'b0, 1'b1);
    all("t5_hunt1", 4'b1011, 2'b00, 0, 0, 0);
    step(1'b0, 1'b0, 1'b1);
    all("t5_hunt2", 4'b1011, 2'b00, 0, 0, 0);
    step(1'b0, 1'b1, 1'b1);
    all("t5_relock", 4'b1011, 2'b01, 0, 0, 1);

    // 6: reset at slot 2, then frame 1,0,0,1
    step(1'b1, 1'b0, 1'b1);
    all("t6_pre", 4'b1011, 2'b10, 0, 0, 1);
    RST_N = 1'b0;
    step(1'b1, 1'b0, 1'b1);
    all("t6_rst", 4'b0000, 2'b00, 0, 0, 0);
    RST_N = 1'b1;
    step(1'b1, 1'b1, 1'b1);
    step(1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b1);
    all("t6_s2", 4'b0000, 2'b11, 0, 0, 1);
    step(1'b1, 1'b0, 1'b1);
    all("t6_s3", 4'b1001, 2'b00, 1, 0, 1);
    step(1'b0, 1'b0, 1'b0);
    all("t6_after", 4'b1001, 2'b00, 0, 0, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
